if_fetch_unit: RTL and testbench

- Consumer end of the next-PC interface: holds the architectural fetch PC (IFpc) and loads it from npc.
- Issues instruction-memory requests at IFpc and tracks the in-flight fetch.
- Presents the fetched instruction to the IF/ID stage.
- Handles pipeline stall, and redirect (branch/jump or CSR trap), including killing a stale in-flight response.

---
 rtl/if_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns IFpc, issues one imem request at a time, presents the
// fetched word to IF/ID, and handles stall/redirect. Optional counters: IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned INST_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [63:0]       npc,
  input  logic              redirect,
  input  logic              stall_if,
  output logic [63:0]       if_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_kill_cnt
);

  localparam int unsigned PC_W  = 64;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              req_valid_q, req_valid_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              kill_q, kill_d;
  logic              req_fire_c;

  assign req_fire_c = req_valid_q & imem_req_ready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect in S_REQ never changes the state by itself
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (req_fire_c) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) state_d = (kill_q || redirect) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (redirect || !stall_if) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Output / datapath next values; kill marks the single in-flight response as stale
  always_comb begin
    pc_d        = pc_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    kill_d      = kill_q;
    req_valid_d = (state_d == S_REQ);
    if (redirect) begin
      pc_d    = npc;
      valid_d = 1'b0;
    end
    unique case (state_q)
      S_REQ: begin
        if (redirect && req_fire_c) kill_d = 1'b1;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q || redirect) begin
            kill_d = 1'b0;
          end else begin
            inst_d  = imem_resp_data;
            valid_d = 1'b1;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall_if) begin
          pc_d    = npc;
          valid_d = 1'b0;
        end
      end
      default: begin
        kill_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      kill_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      kill_q      <= kill_d;
    end
  end

  assign if_pc          = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = req_valid_q;
  assign if_valid       = valid_q;
  assign if_inst        = inst_q;

`ifdef IF_FETCH_PERF_EN
  logic             resp_drop_c;
  logic [CNT_W-1:0] fetch_cnt_q, kill_cnt_q;

  // Discarded response: stale (kill) or dropped by a same-cycle redirect
  assign resp_drop_c = (state_q == S_WAIT) & imem_resp_valid & (kill_q | redirect);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (req_fire_c)  fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      if (resp_drop_c) kill_cnt_q  <= kill_cnt_q + CNT_W'(1);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_kill_cnt  = kill_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a small memory/PC model pushes expected
// instructions when responses are driven; they are popped as if_valid rises.
module tb_if_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rstn;
  logic [63:0] npc;
  logic        redirect;
  logic [63:0] redir_tgt;
  logic        stall_if;
  logic [63:0] if_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;

  if_fetch_unit #(.RESET_PC(RST_PC), .INST_W(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .npc            (npc),
    .redirect       (redirect),
    .stall_if       (stall_if),
    .if_pc          (if_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
  );

  // Next-PC logic stand-in
  assign npc = redirect ? redir_tgt : if_pc + 64'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp;
  logic [63:0] pc_m;
  logic [63:0] pend_addr;
  logic        outstanding, killed_m, prev_valid;
  int          resp_cnt, resp_lat, delivered;
  int unsigned fetches_m, kills_m;
  logic        ovr_en;
  logic [31:0] ovr_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  // One clock: update model with this edge's inputs, advance, drive memory, score output
  task automatic tick();
    logic resp_now, acc_now;
    resp_now = imem_resp_valid;
    acc_now  = imem_req_valid && imem_req_ready;
    if (resp_now) begin
      if (!killed_m && !redirect) sb_q.push_back(imem_resp_data);
      else kills_m++;
      killed_m    = 1'b0;
      outstanding = 1'b0;
    end
    if (acc_now) begin
      chk("req_addr", imem_req_addr, pc_m);
      outstanding = 1'b1;
      fetches_m++;
      pend_addr = pc_m;
      resp_cnt  = resp_lat;
    end
    if (redirect && outstanding && !resp_now) killed_m = 1'b1;
    if (redirect) pc_m = redir_tgt;
    else if (if_valid && !stall_if) pc_m = pc_m + 64'd4;
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (outstanding && resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = ovr_en ? ovr_data : mk_inst(pend_addr);
        ovr_en = 1'b0;
      end
    end
    if (if_valid && !prev_valid) begin
      delivered++;
      if (sb_q.size() == 0) begin
        chk("unexp_valid", 64'(if_valid), 64'd0);
      end else begin
        last_exp = sb_q.pop_front();
        chk("inst", 64'(if_inst), 64'(last_exp));
      end
    end
    prev_valid = if_valid;
  endtask

  task automatic wait_insts(input int n);
    int target;
    target = delivered + n;
    for (int i = 0; i < 200 && delivered < target; i++) tick();
    if (delivered < target) chk("deliver_timeout", 64'(delivered), 64'(target));
  endtask

  // Run until a request is accepted on the next edge, then take that edge
  task automatic to_accept();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (imem_req_valid && imem_req_ready) done = 1'b1;
      tick();
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic model_reset();
    sb_q.delete();
    pc_m            = RST_PC;
    outstanding     = 1'b0;
    killed_m        = 1'b0;
    prev_valid      = 1'b0;
    resp_cnt        = 0;
    fetches_m       = 0;
    kills_m         = 0;
    ovr_en          = 1'b0;
    imem_resp_valid = 1'b0;
  endtask

  task automatic chk_perf(input string tag);
`ifdef IF_FETCH_PERF_EN
    chk({tag, "_fetch"}, 64'(perf_fetch_cnt), 64'(fetches_m));
    chk({tag, "_kill"},  64'(perf_kill_cnt),  64'(kills_m));
`else
    chk({tag, "_fetch"}, 64'(perf_fetch_cnt), 64'd0);
    chk({tag, "_kill"},  64'(perf_kill_cnt),  64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; redirect = 1'b0; redir_tgt = '0; stall_if = 1'b0;
    imem_req_ready = 1'b1; imem_resp_data = '0; resp_lat = 1; delivered = 0;
    last_exp = '0; ovr_data = '0; pend_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", if_pc, RST_PC);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_inst", 64'(if_inst), 64'd0);
    chk_perf("rst_perf");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("req_rise", 64'(imem_req_valid), 64'd1);
    chk("req_addr0", imem_req_addr, RST_PC);

    // Sequential fetch stream
    wait_insts(3);

    // Stall in S_HOLD
    stall_if = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_inst", 64'(if_inst), 64'(last_exp));
      chk("stall_pc", if_pc, pc_m);
      chk("stall_valid", 64'(if_valid), 64'd1);
      chk("stall_noreq", 64'(imem_req_valid), 64'd0);
    end
    stall_if = 1'b0;
    tick();
    chk("unstall_pc", if_pc, pc_m);
    chk("unstall_valid", 64'(if_valid), 64'd0);

    // Redirect while waiting; stale response arrives two cycles later
    resp_lat = 3;
    to_accept();
    resp_lat = 1;
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    redirect = 1'b1; redir_tgt = 64'h0000_0000_8000_0100;
    tick();
    redirect = 1'b0;
    chk("redir_pc", if_pc, 64'h0000_0000_8000_0100);
    wait_insts(1);
    chk_perf("kill_perf");

    // Redirect in the same cycle as the response
    to_accept();
    redirect = 1'b1; redir_tgt = 64'h0000_0000_8000_0200;
    tick();
    redirect = 1'b0;
    chk("same_cyc_valid", 64'(if_valid), 64'd0);
    wait_insts(1);

    // Backpressure on the request, then redirect while not ready
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 64'(imem_req_valid), 64'd1);
      chk("bp_addr", imem_req_addr, pc_m);
    end
    redirect = 1'b1; redir_tgt = 64'h0000_0000_8000_0300;
    tick();
    redirect = 1'b0;
    chk("bp_redir_valid", 64'(imem_req_valid), 64'd1);
    chk("bp_redir_addr", imem_req_addr, 64'h0000_0000_8000_0300);
    imem_req_ready = 1'b1;
    wait_insts(1);

    // Redirect on the very edge a request is accepted
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    redirect = 1'b1; redir_tgt = 64'h0000_0000_8000_0400;
    tick();
    redirect = 1'b0;
    chk("acc_redir_pc", if_pc, 64'h0000_0000_8000_0400);
    wait_insts(2);
    chk_perf("mid_perf");

    // Async reset while a fetch is in flight
    resp_lat = 4;
    to_accept();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pc", if_pc, RST_PC);
    chk("arst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("arst_if_valid", 64'(if_valid), 64'd0);
    model_reset();
    chk_perf("arst_perf");
    resp_lat = 1;
    @(negedge clk);
    rstn = 1'b1;
    wait_insts(2);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk_perf("end_perf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
